// File: rtl/dec_entry_unit.sv
// Decimal-entry front end: debounces three pushbuttons and accumulates MSD-first
// decimal digits into a 16-bit binary value. On enter, the value is offered to the CPU
// with a valid/ack handshake. A BCD echo of the digits drives the HEX displays.
module dec_entry_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw_digit,
  input  logic        key_digit_n,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  input  logic        rd_ack,
  output logic [15:0] value,
  output logic        valid,
  output logic [15:0] bcd,
  output logic [2:0]  digit_count,
  output logic        err
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] MaxCnt = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {StIdle, StEntry, StReady} state_e;

  // Bit 0 = digit key, bit 1 = enter key, bit 2 = clear key.
  logic [2:0] key_raw;
  logic [2:0] sync1_q, sync2_q, deb_q, press_q, armed_q;
  logic [1:0] fill_q;
  logic [CntW-1:0] cnt_q [3];

  state_e state_q;
  logic [15:0] accum_q;

  assign key_raw = {key_clear_n, key_enter_n, key_digit_n};

  // Key conditioning: 2-flop sync, stability counter, registered press pulse.
  // fill_q marks when sync2_q holds a real post-reset sample; a key is only armed once
  // it has really been seen released, so a key held through reset makes no press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      armed_q <= '0;
      fill_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (fill_q[1] && sync2_q[i]) armed_q[i] <= 1'b1;
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            deb_q[i]   <= sync2_q[i];
            cnt_q[i]   <= '0;
            // deb_q high here means the accepted change is a 1->0 press
            press_q[i] <= deb_q[i] & armed_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Entry FSM with registered outputs; priority clear > rd_ack > enter > digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      accum_q     <= '0;
      value       <= '0;
      valid       <= 1'b0;
      bcd         <= '0;
      digit_count <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (press_q[2]) begin
        state_q     <= StIdle;
        accum_q     <= '0;
        bcd         <= '0;
        digit_count <= '0;
        valid       <= 1'b0;
      end else if (rd_ack && valid) begin
        state_q     <= StIdle;
        accum_q     <= '0;
        bcd         <= '0;
        digit_count <= '0;
        valid       <= 1'b0;
      end else if (press_q[1]) begin
        if (state_q != StReady) begin
          state_q <= StReady;
          value   <= accum_q;
          valid   <= 1'b1;
        end
      end else if (press_q[0]) begin
        if (sw_digit <= 4'd9 && digit_count < MaxCnt && state_q != StReady) begin
          state_q     <= StEntry;
          accum_q     <= accum_q * 16'd10 + {12'd0, sw_digit};
          bcd         <= {bcd[11:0], sw_digit};
          digit_count <= digit_count + 3'd1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_entry_unit.sv
// Bench for dec_entry_unit: a digit-list model of the entry unit with a sliding-window
// debounce model, checked every cycle, plus hand-computed literal checks.
module tb_dec_entry_unit;

  localparam int unsigned D    = 4;
  localparam int unsigned MAXD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = 4'd0;
  logic        kd = 1'b1, ke = 1'b1, kc = 1'b1, ack = 1'b0;
  logic [15:0] value, bcd;
  logic        valid, err;
  logic [2:0]  digit_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dec_entry_unit #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .sw_digit(sw), .key_digit_n(kd), .key_enter_n(ke),
    .key_clear_n(kc), .rd_ack(ack), .value(value), .valid(valid), .bcd(bcd),
    .digit_count(digit_count), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit          hist [3][$];   // raw key samples per edge since reset
  bit          mdb [3];
  bit          marm [3];
  bit          mpress [3];
  int          mdig [$];      // digits entered, oldest first
  bit          mready;
  logic [15:0] mvalue;
  bit          merr;

  function automatic bit syncv(input int i, input int j);
    // level seen by the debouncer at edge j: raw sampled two edges earlier
    return (j >= 3) ? hist[i][j-3] : 1'b1;
  endfunction

  function automatic logic [15:0] to_num();
    int s = 0;
    foreach (mdig[n]) s = s * 10 + mdig[n];
    return 16'(s);
  endfunction

  function automatic logic [15:0] to_bcd();
    logic [15:0] b = '0;
    foreach (mdig[n]) b = {b[11:0], 4'(mdig[n])};
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        hist[i].delete();
        mdb[i] = 1'b1;
        marm[i] = 1'b0;
        mpress[i] = 1'b0;
      end
      mdig.delete();
      mready = 1'b0;
      mvalue = '0;
      merr = 1'b0;
    end else begin
      bit [2:0] raw;
      merr = 1'b0;
      if (mpress[2]) begin
        mdig.delete();
        mready = 1'b0;
      end else if (ack && mready) begin
        mdig.delete();
        mready = 1'b0;
      end else if (mpress[1]) begin
        if (!mready) begin
          mvalue = to_num();
          mready = 1'b1;
        end
      end else if (mpress[0]) begin
        if (sw <= 4'd9 && mdig.size() < MAXD && !mready) mdig.push_back(int'(sw));
        else merr = 1'b1;
      end
      raw = {kc, ke, kd};
      for (int i = 0; i < 3; i++) begin
        int  k;
        bit  flip;
        hist[i].push_back(raw[i]);
        k = hist[i].size();
        // the debounced level flips once D consecutive samples all disagree with it
        flip = (k >= int'(D));
        if (flip) begin
          for (int j = k - int'(D) + 1; j <= k; j++) if (syncv(i, j) == mdb[i]) flip = 1'b0;
        end
        mpress[i] = 1'b0;
        if (flip) begin
          mpress[i] = mdb[i] && marm[i];
          mdb[i] = ~mdb[i];
        end
        if (k >= 3 && syncv(i, k)) marm[i] = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("value", 32'(value), 32'(mvalue));
      chk("valid", 32'(valid), 32'(mready));
      chk("bcd", 32'(bcd), 32'(to_bcd()));
      chk("digit_count", 32'(digit_count), 32'(mdig.size()));
      chk("err", 32'(err), 32'(merr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic lvl);
    case (k)
      0: kd = lvl;
      1: ke = lvl;
      default: kc = lvl;
    endcase
  endtask

  task automatic press(input int k, input logic [3:0] d, output bit saw);
    saw = 1'b0;
    @(negedge clk);
    sw = d;
    set_key(k, 1'b0);
    repeat (D + 6) begin @(negedge clk); saw |= err; end
    set_key(k, 1'b1);
    repeat (D + 6) begin @(negedge clk); saw |= err; end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    int lat;
    logic [2:0] prev;

    idle(3);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    #2 rst_n = 1'b1;
    idle(5);

    // 1: 1,2,3,4 enter, then ack
    for (int n = 1; n <= 4; n++) press(0, 4'(n), saw);
    press(1, 4'd0, saw);
    chk("t1_value", 32'(value), 32'h04D2);
    chk("t1_valid", 32'(valid), 32'h1);
    chk("t1_bcd", 32'(bcd), 32'h1234);
    chk("t1_count", 32'(digit_count), 32'h4);
    ack_pulse();
    chk("t1_ack_valid", 32'(valid), 32'h0);
    chk("t1_ack_bcd", 32'(bcd), 32'h0);
    chk("t1_ack_count", 32'(digit_count), 32'h0);

    // 2: bouncing digit key, one press 2+D cycles after the last toggle
    @(negedge clk);
    sw = 4'd5;
    for (int t = 0; t < 4; t++) begin
      kd = (t % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    kd = 1'b0;
    prev = digit_count;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (digit_count != prev) begin
        lat = n;
        break;
      end
    end
    // press pulse at edge 2+D, register update one edge later
    chk("t2_latency", 32'(lat), 32'(D + 3));
    idle(6);
    kd = 1'b1;
    idle(12);
    chk("t2_count", 32'(digit_count), 32'h1);
    chk("t2_bcd", 32'(bcd), 32'h0005);
    press(2, 4'd0, saw);

    // 3: overflow digit and out-of-range digit
    for (int n = 0; n < 4; n++) press(0, 4'd9, saw);
    press(0, 4'd5, saw);
    chk("t3_fifth_err", 32'(saw), 32'h1);
    press(1, 4'd0, saw);
    chk("t3_value", 32'(value), 32'h270F);
    chk("t3_bcd", 32'(bcd), 32'h9999);
    ack_pulse();
    press(0, 4'd12, saw);
    chk("t3_bad_err", 32'(saw), 32'h1);
    chk("t3_bad_count", 32'(digit_count), 32'h0);
    press(0, 4'd3, saw);
    press(1, 4'd0, saw);
    chk("t3_accum_kept", 32'(value), 32'h3);
    ack_pulse();

    // 4: empty enter, digit while ready
    press(1, 4'd0, saw);
    chk("t4_valid", 32'(valid), 32'h1);
    chk("t4_value", 32'(value), 32'h0);
    press(0, 4'd6, saw);
    chk("t4_ready_err", 32'(saw), 32'h1);
    chk("t4_value_hold", 32'(value), 32'h0);
    ack_pulse();

    // 5: clear, then clear+enter together
    press(0, 4'd7, saw);
    press(0, 4'd8, saw);
    chk("t5_pre_bcd", 32'(bcd), 32'h0078);
    press(2, 4'd0, saw);
    chk("t5_count", 32'(digit_count), 32'h0);
    chk("t5_bcd", 32'(bcd), 32'h0);
    chk("t5_valid", 32'(valid), 32'h0);
    press(0, 4'd5, saw);
    @(negedge clk);
    kc = 1'b0;
    ke = 1'b0;
    idle(D + 6);
    kc = 1'b1;
    ke = 1'b1;
    idle(D + 6);
    chk("t5_both_valid", 32'(valid), 32'h0);
    chk("t5_both_count", 32'(digit_count), 32'h0);

    // 6: reset mid-debounce with digits held, key kept low across reset
    press(0, 4'd1, saw);
    press(0, 4'd2, saw);
    @(negedge clk);
    sw = 4'd4;
    kd = 1'b0;
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_value", 32'(value), 32'h0);
    chk("t6_rst_bcd", 32'(bcd), 32'h0);
    chk("t6_rst_count", 32'(digit_count), 32'h0);
    chk("t6_rst_valid", 32'(valid), 32'h0);
    idle(2);
    #2 rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin @(negedge clk); saw |= err; end
    chk("t6_no_press", 32'(digit_count), 32'h0);
    chk("t6_no_err", 32'(saw), 32'h0);
    kd = 1'b1;
    idle(12);
    press(0, 4'd4, saw);
    chk("t6_recover", 32'(bcd), 32'h0004);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
